// File: rtl/tft_spi_sequencer_if.sv
// tft_spi_sequencer bus: init ROM, serializer word and pixel handshakes.
// master = sequencer side, slave = ROM / serializer / pixel source side.
interface tft_spi_sequencer_if #(
  parameter int ROM_AW = 6
);
  logic [ROM_AW-1:0] rom_addr;
  logic [17:0]       rom_data;
  logic              word_valid;
  logic [16:0]       word_data;
  logic              word_ready;
  logic              frame_req;
  logic              pixel_valid;
  logic [15:0]       pixel_data;
  logic              pixel_ready;
  logic              lcd_rst_n;
  logic              init_done;
  logic              frame_done;

  modport master (
    output rom_addr,
    input  rom_data,
    output word_valid,
    output word_data,
    input  word_ready,
    input  frame_req,
    input  pixel_valid,
    input  pixel_data,
    output pixel_ready,
    output lcd_rst_n,
    output init_done,
    output frame_done
  );

  modport slave (
    input  rom_addr,
    output rom_data,
    input  word_valid,
    input  word_data,
    output word_ready,
    output frame_req,
    output pixel_valid,
    output pixel_data,
    input  pixel_ready,
    input  lcd_rst_n,
    input  init_done,
    input  frame_done
  );
endinterface

// File: rtl/tft_spi_sequencer.sv
// TFT SPI sequencer: panel reset, init ROM walk, RAMWR + RGB565 frames.
// Define TFT_SEQ_WINDOW_EN to send CASET/PASET before every RAMWR.
module tft_spi_sequencer #(
  parameter int ROM_AW     = 6,
  parameter int CLK_PER_MS = 1000,
  parameter int RST_LOW    = 100,
  parameter int RST_WAIT   = 5000,
  parameter int WIDTH      = 240,
  parameter int HEIGHT     = 320
) (
  input logic SPI_CLK,
  input logic reset,
  tft_spi_sequencer_if.master bus
);
  localparam int CW = 32;

  localparam logic [3:0] S_RST_LO = 4'd0;
  localparam logic [3:0] S_RST_HI = 4'd1;
  localparam logic [3:0] S_FETCH  = 4'd2;
  localparam logic [3:0] S_EXEC   = 4'd3;
  localparam logic [3:0] S_DELAY  = 4'd4;
  localparam logic [3:0] S_READY  = 4'd5;
  localparam logic [3:0] S_FCMD   = 4'd7;
  localparam logic [3:0] S_FPIX   = 4'd8;
`ifdef TFT_SEQ_WINDOW_EN
  localparam logic [3:0] S_WIN    = 4'd6;
`endif

  localparam logic [CW-1:0] LO_LAST  = CW'(RST_LOW - 1);
  localparam logic [CW-1:0] HI_LAST  = CW'(RST_WAIT - 1);
  localparam logic [CW-1:0] PIX_LAST = CW'(WIDTH * HEIGHT - 1);
  localparam logic [CW-1:0] CPM      = CW'(CLK_PER_MS);
  localparam logic [ROM_AW-1:0] ROM_LAST = '1;

  logic [3:0]        state;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     dly_last;
  logic [ROM_AW-1:0] addr;
  logic              init_q;
  logic              fdone_q;
  logic [1:0]        op;
  logic [15:0]       pay;

  assign op  = bus.rom_data[17:16];
  assign pay = bus.rom_data[15:0];

  assign bus.rom_addr   = addr;
  assign bus.lcd_rst_n  = (state != S_RST_LO);
  assign bus.init_done  = init_q;
  assign bus.frame_done = fdone_q;

`ifdef TFT_SEQ_WINDOW_EN
  logic [16:0] win_word;

  // CASET then PASET words, indexed by cnt while in S_WIN
  always_comb begin
    win_word = {1'b1, 16'(HEIGHT - 1)};
    case (cnt[2:0])
      3'd0:    win_word = {1'b0, 16'h002A};
      3'd1:    win_word = {1'b1, 16'h0000};
      3'd2:    win_word = {1'b1, 16'(WIDTH - 1)};
      3'd3:    win_word = {1'b0, 16'h002B};
      3'd4:    win_word = {1'b1, 16'h0000};
      default: win_word = {1'b1, 16'(HEIGHT - 1)};
    endcase
  end
`endif

  // serializer / pixel handshake outputs; FPIX is a pure pass-through
  always_comb begin
    bus.word_valid  = 1'b0;
    bus.word_data   = {op[0], pay};
    bus.pixel_ready = 1'b0;
    unique case (1'b1)
      (state == S_EXEC): bus.word_valid = ~op[1];
`ifdef TFT_SEQ_WINDOW_EN
      (state == S_WIN): begin
        bus.word_valid = 1'b1;
        bus.word_data  = win_word;
      end
`endif
      (state == S_FCMD): begin
        bus.word_valid = 1'b1;
        bus.word_data  = {1'b0, 16'h002C};
      end
      (state == S_FPIX): begin
        bus.word_valid  = bus.pixel_valid;
        bus.word_data   = {1'b1, bus.pixel_data};
        bus.pixel_ready = bus.word_ready;
      end
      default: ;
    endcase
  end

  // sequencer FSM, counters and ROM pointer
  always_ff @(posedge SPI_CLK) begin
    if (reset) begin
      state    <= S_RST_LO;
      cnt      <= '0;
      dly_last <= '0;
      addr     <= '0;
      init_q   <= 1'b0;
      fdone_q  <= 1'b0;
    end else begin
      fdone_q <= 1'b0;
      case (state)
        S_RST_LO: begin
          if (cnt == LO_LAST) begin
            state <= S_RST_HI;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_RST_HI: begin
          if (cnt == HI_LAST) begin
            state <= S_FETCH;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          case (op)
            2'b11: begin
              init_q <= 1'b1;
              state  <= S_READY;
            end
            2'b10: begin
              cnt      <= '0;
              dly_last <= (pay == 16'd0) ? '0
                        : CW'(pay) * CPM - 1'b1;
              state    <= S_DELAY;
            end
            default: begin
              if (bus.word_ready) begin
                if (addr == ROM_LAST) begin
                  init_q <= 1'b1;
                  state  <= S_READY;
                end else begin
                  addr  <= addr + 1'b1;
                  state <= S_FETCH;
                end
              end
            end
          endcase
        end
        S_DELAY: begin
          if (cnt == dly_last) begin
            cnt <= '0;
            if (addr == ROM_LAST) begin
              init_q <= 1'b1;
              state  <= S_READY;
            end else begin
              addr  <= addr + 1'b1;
              state <= S_FETCH;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_READY: begin
          if (bus.frame_req) begin
            cnt   <= '0;
`ifdef TFT_SEQ_WINDOW_EN
            state <= S_WIN;
`else
            state <= S_FCMD;
`endif
          end
        end
`ifdef TFT_SEQ_WINDOW_EN
        S_WIN: begin
          if (bus.word_ready) begin
            if (cnt == CW'(5)) begin
              cnt   <= '0;
              state <= S_FCMD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
`endif
        S_FCMD: begin
          if (bus.word_ready) begin
            cnt   <= '0;
            state <= S_FPIX;
          end
        end
        S_FPIX: begin
          if (bus.pixel_valid && bus.word_ready) begin
            if (cnt == PIX_LAST) begin
              fdone_q <= 1'b1;
              cnt     <= '0;
              state   <= S_READY;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= S_RST_LO;
      endcase
    end
  end
endmodule

// File: tb/tb_tft_spi_sequencer.sv
// Randomized self-checking bench for tft_spi_sequencer.
// Reference: ROM program walk and frame word lists built from the rules.
module tb_tft_spi_sequencer;
  localparam int AW   = 4;
  localparam int CPM  = 3;
  localparam int RLO  = 4;
  localparam int RWT  = 8;
  localparam int W    = 4;
  localparam int H    = 2;
  localparam int NPIX = W * H;

  logic SPI_CLK = 1'b0;
  logic reset   = 1'b1;

  tft_spi_sequencer_if #(.ROM_AW(AW)) bus ();

  tft_spi_sequencer #(
    .ROM_AW(AW), .CLK_PER_MS(CPM),
    .RST_LOW(RLO), .RST_WAIT(RWT),
    .WIDTH(W), .HEIGHT(H)
  ) dut (
    .SPI_CLK(SPI_CLK),
    .reset(reset),
    .bus(bus)
  );

  always #5 SPI_CLK = ~SPI_CLK;

  logic [17:0] rom [16];
  always @(posedge SPI_CLK) bus.rom_data <= rom[bus.rom_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int hold_err = 0;
  logic pend = 1'b0;
  logic [16:0] pd = '0;
  logic [16:0] got[$];
  int gotc[$];
  logic [16:0] exp_q[$];
  int mg[$];
  logic [15:0] pix [NPIX];

  always @(posedge SPI_CLK) cyc <= cyc + 1;

  // word monitor: records accepted words, flags unstable held words
  always @(negedge SPI_CLK) begin
    if (reset) begin
      pend <= 1'b0;
    end else begin
      if (pend && (!bus.word_valid || bus.word_data !== pd))
        hold_err <= hold_err + 1;
      if (bus.word_valid && bus.word_ready) begin
        got.push_back(bus.word_data);
        gotc.push_back(cyc);
      end
      pend <= bus.word_valid && !bus.word_ready;
      pd   <= bus.word_data;
    end
  end

  task automatic load_rom(input bit with_end);
    int n;
    int r;
    logic [1:0] op;
    logic [15:0] p;
    n = with_end ? int'($urandom_range(3, 10)) : 16;
    for (int i = 0; i < 16; i++) begin
      r = $urandom_range(0, 5);
      if (i == 0) op = 2'b00;
      else if (r < 2) op = 2'b00;
      else if (r < 4) op = 2'b01;
      else op = 2'b10;
      p = (op == 2'b10) ? 16'($urandom_range(0, 2))
                        : 16'($urandom);
      rom[i] = {op, p};
      if (with_end && i == n) rom[i] = {2'b11, 16'h0};
    end
  endtask

  function automatic void build_init_exp();
    int d = 0;
    exp_q.delete();
    mg.delete();
    for (int i = 0; i < 16; i++) begin
      logic [1:0] op;
      int p;
      op = rom[i][17:16];
      p  = int'(rom[i][15:0]);
      if (op == 2'b11) break;
      if (op[1] == 1'b0) begin
        exp_q.push_back({op[0], rom[i][15:0]});
        mg.push_back(2 + d);
        d = 0;
      end else begin
        d += 2 + ((p == 0) ? 1 : p * CPM);
      end
    end
  endfunction

  function automatic void build_frame_exp();
    exp_q.delete();
`ifdef TFT_SEQ_WINDOW_EN
    exp_q.push_back({1'b0, 16'h002A});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b1, 16'(W - 1)});
    exp_q.push_back({1'b0, 16'h002B});
    exp_q.push_back({1'b1, 16'h0000});
    exp_q.push_back({1'b1, 16'(H - 1)});
`endif
    exp_q.push_back({1'b0, 16'h002C});
    for (int i = 0; i < NPIX; i++)
      exp_q.push_back({1'b1, pix[i]});
  endfunction

  // stimulus only: runs one frame with a hold-until-accepted pixel source
  task automatic drive_frame(input int rdy_pct, input bit do_req,
                             input bit inject, output int acc,
                             output int fd_n, output int fd_gap,
                             output bit tmo);
    int k = 0;
    int n = 0;
    int last = -1;
    int fdc = -1;
    bit a;
    acc = 0;
    fd_n = 0;
    for (int i = 0; i < NPIX; i++) pix[i] = 16'($urandom);
    @(posedge SPI_CLK); #1;
    if (do_req) begin
      bus.frame_req = 1'b1;
      @(posedge SPI_CLK); #1;
      bus.frame_req = 1'b0;
    end
    bus.pixel_valid = 1'b0;
    bus.pixel_data  = pix[0];
    while (n < 600) begin
      @(negedge SPI_CLK);
      n++;
      a = bus.pixel_valid && bus.pixel_ready;
      if (bus.frame_done) begin
        fd_n++;
        if (fdc < 0) fdc = n;
      end
      if (a) begin
        acc++;
        last = n;
      end
      @(posedge SPI_CLK); #1;
      if (a) k++;
      if (k < NPIX) bus.pixel_data = pix[k];
      if (!bus.pixel_valid || a)
        bus.pixel_valid = (k < NPIX) && ($urandom_range(0, 99) < 60);
      bus.word_ready = ($urandom_range(0, 99) < rdy_pct);
      bus.frame_req = inject && (n == 4);
      if (fdc > 0 && n >= fdc + 3) break;
    end
    bus.pixel_valid = 1'b0;
    bus.frame_req   = 1'b0;
    bus.word_ready  = 1'b1;
    tmo = (fdc < 0);
    fd_gap = fdc - last;
  endtask

  task automatic test_reset();
    int n = 0;
    bit bad = 0;
    load_rom(1'b1);
    bus.word_ready = 1'b1;
    reset = 1'b1;
    repeat (3) @(posedge SPI_CLK);
    @(negedge SPI_CLK);
    reset = 1'b0;
    got.delete();
    gotc.delete();
    checks++;
    if (bus.lcd_rst_n !== 1'b0 || bus.word_valid !== 1'b0 ||
        bus.init_done !== 1'b0 || bus.frame_done !== 1'b0 ||
        bus.pixel_ready !== 1'b0 || bus.rom_addr !== '0) begin
      errors++;
      $display("FAIL reset_state rst_n=%b wv=%b id=%b fd=%b pr=%b a=%0d",
               bus.lcd_rst_n, bus.word_valid, bus.init_done,
               bus.frame_done, bus.pixel_ready, bus.rom_addr);
    end
    while (bus.lcd_rst_n === 1'b0 && n < 50) begin
      n++;
      @(negedge SPI_CLK);
    end
    checks++;
    if (n !== RLO) begin
      errors++;
      $display("FAIL rst_low_len got %0d want %0d", n, RLO);
    end
    n = 0;
    while (bus.word_valid !== 1'b1 && n < 100) begin
      if (bus.rom_addr !== '0) bad = 1;
      n++;
      @(negedge SPI_CLK);
    end
    checks++;
    if (n !== RWT + 1 || bad) begin
      errors++;
      $display("FAIL rst_wait_len got %0d want %0d addr_moved=%0d",
               n, RWT + 1, bad);
    end
    checks++;
    if (bus.init_done !== 1'b0) begin
      errors++;
      $display("FAIL init_done_early got %b want 0", bus.init_done);
    end
  endtask

  task automatic test_init();
    int n = 0;
    int bg = 0;
    while (n < 3000 && bus.init_done !== 1'b1) begin
      @(posedge SPI_CLK); #1;
      bus.word_ready = ($urandom_range(0, 99) < 70);
      n++;
    end
    bus.word_ready = 1'b1;
    @(negedge SPI_CLK);
    build_init_exp();
    checks++;
    if (bus.init_done !== 1'b1) begin
      errors++;
      $display("FAIL init_done got %b want 1", bus.init_done);
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL init_count got %0d want %0d",
               got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL init_word[%0d] got %h want %h",
                 i, got[i], exp_q[i]);
      end
      if (i > 0 && gotc[i] - gotc[i-1] < mg[i]) bg++;
    end
    checks++;
    if (bg != 0) begin
      errors++;
      $display("FAIL init_gaps got %0d short gaps want 0", bg);
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL init_hold got %0d want 0", hold_err);
    end
  endtask

  task automatic test_frame(input int rdy_pct);
    int acc, fdn, fdg;
    bit tmo;
    got.delete();
    drive_frame(rdy_pct, 1'b1, 1'b0, acc, fdn, fdg, tmo);
    build_frame_exp();
    checks++;
    if (tmo || acc != NPIX || fdn != 1 || fdg != 1) begin
      errors++;
      $display("FAIL frame_ctl tmo=%0d acc=%0d fd=%0d gap=%0d want 0 %0d 1 1",
               tmo, acc, fdn, fdg, NPIX);
    end
    checks++;
    if (got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL frame_count got %0d want %0d",
               got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL frame_word[%0d] got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_stall();
    int acc, fdn, fdg;
    bit tmo;
    int bad = 0;
    logic [16:0] first;
    got.delete();
    @(posedge SPI_CLK); #1;
    bus.word_ready = 1'b0;
    bus.frame_req  = 1'b1;
    @(posedge SPI_CLK); #1;
    bus.frame_req  = 1'b0;
    build_frame_exp();
    first = exp_q[0];
    repeat (5) begin
      @(negedge SPI_CLK);
      if (bus.word_valid !== 1'b1 || bus.word_data !== first ||
          bus.pixel_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL stall_hold got %0d bad cycles want 0 (wv=%b wd=%h)",
               bad, bus.word_valid, bus.word_data);
    end
    drive_frame(70, 1'b0, 1'b0, acc, fdn, fdg, tmo);
    build_frame_exp();
    checks++;
    if (tmo || acc != NPIX || fdn != 1 || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL stall_frame acc=%0d fd=%0d n=%0d want %0d 1 %0d",
               acc, fdn, got.size(), NPIX, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL stall_word[%0d] got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
    checks++;
    if (hold_err != 0) begin
      errors++;
      $display("FAIL stall_hold_mon got %0d want 0", hold_err);
    end
  endtask

  task automatic test_back_to_back();
    int acc, fdn, fdg;
    bit tmo;
    got.delete();
    drive_frame(100, 1'b1, 1'b1, acc, fdn, fdg, tmo);
    repeat (20) @(negedge SPI_CLK);
    build_frame_exp();
    checks++;
    if (tmo || acc != NPIX || fdn != 1 || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL ignored_req acc=%0d fd=%0d n=%0d want %0d 1 %0d",
               acc, fdn, got.size(), NPIX, exp_q.size());
    end
    got.delete();
    drive_frame(80, 1'b1, 1'b0, acc, fdn, fdg, tmo);
    build_frame_exp();
    checks++;
    if (tmo || acc != NPIX || fdg != 1 || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_frame acc=%0d gap=%0d n=%0d want %0d 1 %0d",
               acc, fdg, got.size(), NPIX, exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL b2b_word[%0d] got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int bad = 0;
    @(posedge SPI_CLK); #1;
    bus.word_ready  = 1'b1;
    bus.frame_req   = 1'b1;
    @(posedge SPI_CLK); #1;
    bus.frame_req   = 1'b0;
    bus.pixel_valid = 1'b1;
    bus.pixel_data  = 16'($urandom);
    repeat (3) @(posedge SPI_CLK);
    #1;
    reset = 1'b1;
    bus.frame_req = 1'b1;
    @(posedge SPI_CLK); #1;
    checks++;
    if (bus.word_valid !== 1'b0 || bus.lcd_rst_n !== 1'b0 ||
        bus.init_done !== 1'b0 || bus.pixel_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset wv=%b rst_n=%b id=%b pr=%b want 0 0 0 0",
               bus.word_valid, bus.lcd_rst_n, bus.init_done,
               bus.pixel_ready);
    end
    load_rom(1'b0);
    @(posedge SPI_CLK); #1;
    reset = 1'b0;
    bus.pixel_valid = 1'b0;
    got.delete();
    gotc.delete();
    @(posedge SPI_CLK); #1;
    bus.frame_req = 1'b0;
    repeat (RLO + RWT) begin
      @(negedge SPI_CLK);
      if (bus.word_valid !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL mid_reset_idle got %0d valid cycles want 0", bad);
    end
  endtask

  task automatic test_rom_full();
    int n = 0;
    while (n < 3000 && bus.init_done !== 1'b1) begin
      @(posedge SPI_CLK); #1;
      bus.word_ready = ($urandom_range(0, 99) < 70);
      n++;
    end
    bus.word_ready = 1'b1;
    @(negedge SPI_CLK);
    build_init_exp();
    checks++;
    if (bus.init_done !== 1'b1 || got.size() != exp_q.size()) begin
      errors++;
      $display("FAIL rom_full id=%b n=%0d want 1 %0d",
               bus.init_done, got.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got.size(); i++) begin
      checks++;
      if (got[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL full_word[%0d] got %h want %h",
                 i, got[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    bus.word_ready  = 1'b1;
    bus.frame_req   = 1'b0;
    bus.pixel_valid = 1'b0;
    bus.pixel_data  = '0;
    test_reset();
    test_init();
    test_frame(100);
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_rom_full();
    test_frame(75);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
